pw_phase_shift_ctrl: RTL



---
 rtl/pw_phase_shift_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pw_phase_shift_ctrl.sv
// Dynamic phase-shift sequencer for the trigger-clock MMCM: walks the applied
// phase toward a signed target one psen/psdone step at a time.
`timescale 1ns/1ps
module pw_phase_shift_ctrl #(
  parameter int pPHASE_WIDTH = 10,
  parameter int pTIMEOUT     = 64
) (
  input  logic                    usb_clk,
  input  logic                    reset_n,
  input  logic [pPHASE_WIDTH-1:0] I_target,
  input  logic                    I_go,
  input  logic                    I_locked,
  input  logic                    I_psdone,
  output logic                    O_psen,
  output logic                    O_psincdec,
  output logic                    O_busy,
  output logic                    O_done,
  output logic                    O_error,
  output logic [pPHASE_WIDTH-1:0] O_current
);

  localparam int                      CNT_W    = (pTIMEOUT > 2) ? $clog2(pTIMEOUT) : 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(pTIMEOUT - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [pPHASE_WIDTH-1:0] PH_ONE   = pPHASE_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP,
    ST_STEP,
    ST_WAIT
  } state_t;

  state_t                    state_q,    state_d;
  logic [pPHASE_WIDTH-1:0]   target_q,   target_d;
  logic [pPHASE_WIDTH-1:0]   current_q,  current_d;
  logic [CNT_W-1:0]          cnt_q,      cnt_d;
  logic                      psen_q,     psen_d;
  logic                      psincdec_q, psincdec_d;
  logic                      busy_q,     busy_d;
  logic                      done_q,     done_d;
  logic                      error_q,    error_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d    = state_q;
    target_d   = target_q;
    current_d  = current_q;
    cnt_d      = cnt_q;
    psincdec_d = psincdec_q;
    busy_d     = busy_q;
    error_d    = error_q;
    psen_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (I_go) begin
          if (I_locked) begin
            target_d = I_target;
            error_d  = 1'b0;
            busy_d   = 1'b1;
            state_d  = ST_CMP;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ST_CMP: begin
        if (current_q == target_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          psincdec_d = ($signed(target_q) > $signed(current_q));
          psen_d     = 1'b1;
          state_d    = ST_STEP;
        end
      end
      ST_STEP: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (I_psdone) begin
          current_d = psincdec_q ? (current_q + PH_ONE) : (current_q - PH_ONE);
          state_d   = ST_CMP;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A retarget only moves the goal; the step already issued still completes.
    if (state_q != ST_IDLE && I_go) begin
      target_d = I_target;
    end

    // The MMCM resets its phase on relock, so the tracked phase is discarded.
    if (state_q != ST_IDLE && !I_locked) begin
      state_d   = ST_IDLE;
      current_d = '0;
      busy_d    = 1'b0;
      error_d   = 1'b1;
      done_d    = 1'b1;
      psen_d    = 1'b0;
    end
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      current_q  <= '0;
      cnt_q      <= '0;
      psen_q     <= 1'b0;
      psincdec_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      target_q   <= target_d;
      current_q  <= current_d;
      cnt_q      <= cnt_d;
      psen_q     <= psen_d;
      psincdec_q <= psincdec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign O_psen     = psen_q;
  assign O_psincdec = psincdec_q;
  assign O_busy     = busy_q;
  assign O_done     = done_q;
  assign O_error    = error_q;
  assign O_current  = current_q;

endmodule
